// File: rtl/regbank_pkg.sv
// Shared constants and read-FSM encoding for the operand-read register bank.
package regbank_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 4;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } rd_state_t;

endpackage

// File: rtl/regbank_toggle_sync.sv
// Two-flop synchroniser for a request toggle plus the last-accepted phase;
// a request stays pending until the consumer accepts it.
module toggle_sync (
  input  logic clk,
  input  logic reset,
  input  logic toggleIn,
  input  logic accept,
  output logic pending
);

  logic s1_r;
  logic s2_r;
  logic acc_r;

  // Synchroniser chain and accepted-phase register
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r  <= 1'b0;
      s2_r  <= 1'b0;
      acc_r <= 1'b0;
    end else begin
      s1_r <= toggleIn;
      s2_r <= s1_r;
      if (accept) begin
        acc_r <= s2_r;
      end
    end
  end

  assign pending = (s2_r != acc_r);

endmodule

// File: rtl/regbank_responder.sv
// 16 x 32-bit register bank answering toggle-handshake reads (two-state FSM)
// and toggle-handshake writes, with write-through forwarding into a read.
module regbank_responder
  import regbank_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              triggerIn,
  input  logic [DATA_W-1:0] addrIn,
  output logic [DATA_W-1:0] dataOut,
  output logic              readyOut,
  output logic              triggerOut,
  input  logic              wTriggerIn,
  input  logic [ADDR_W-1:0] wAddrIn,
  input  logic [DATA_W-1:0] wDataIn,
  output logic              wTriggerOut
);

  rd_state_t         state_r;
  rd_state_t         state_next_s;
  logic              rd_pending_s;
  logic              wr_pending_s;
  logic              rd_accept_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] regs_r [NUM_REGS];
  logic [DATA_W-1:0] rd_data_s;
  logic              unused_addr_hi_s;

  assign unused_addr_hi_s = ^addrIn[DATA_W-1:ADDR_W];

  toggle_sync u_rd_sync (
    .clk      (clk),
    .reset    (reset),
    .toggleIn (triggerIn),
    .accept   (rd_accept_s),
    .pending  (rd_pending_s)
  );

  toggle_sync u_wr_sync (
    .clk      (clk),
    .reset    (reset),
    .toggleIn (wTriggerIn),
    .accept   (wr_pending_s),
    .pending  (wr_pending_s)
  );

  // Read FSM next state; a request is only accepted from IDLE
  always_comb begin
    state_next_s = state_r;
    rd_accept_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (rd_pending_s) begin
          rd_accept_s  = 1'b1;
          state_next_s = READ;
        end else begin
          state_next_s = IDLE;
        end
      end
      READ:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Read data source: a write committing on the same edge wins
  always_comb begin
    rd_data_s = regs_r[addr_r];
    if (wr_pending_s && (wAddrIn == addr_r)) begin
      rd_data_s = wDataIn;
    end else begin
      rd_data_s = regs_r[addr_r];
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Register array and write acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
      wTriggerOut <= 1'b0;
    end else if (wr_pending_s) begin
      regs_r[wAddrIn] <= wDataIn;
      wTriggerOut     <= ~wTriggerOut;
    end
  end

  // Read address capture, read data and read acknowledge
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_r     <= '0;
      dataOut    <= '0;
      readyOut   <= 1'b0;
      triggerOut <= 1'b0;
    end else if (rd_accept_s) begin
      addr_r   <= addrIn[ADDR_W-1:0];
      readyOut <= 1'b0;
    end else if (state_r == READ) begin
      dataOut    <= rd_data_s;
      readyOut   <= 1'b1;
      triggerOut <= ~triggerOut;
    end
  end

endmodule

// File: tb/tb_regbank_responder.sv
// Self-checking bench for regbank_responder: directed corner sequences,
// a vector table, and randomized traffic against an array model.
module tb_regbank_responder;

  logic        clk;
  logic        reset;
  logic        triggerIn;
  logic [31:0] addrIn;
  logic [31:0] dataOut;
  logic        readyOut;
  logic        triggerOut;
  logic        wTriggerIn;
  logic [3:0]  wAddrIn;
  logic [31:0] wDataIn;
  logic        wTriggerOut;

  int          n_checks;
  int          n_fail;
  logic [31:0] model_regs [16];

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  regbank_responder dut (
    .clk         (clk),
    .reset       (reset),
    .triggerIn   (triggerIn),
    .addrIn      (addrIn),
    .dataOut     (dataOut),
    .readyOut    (readyOut),
    .triggerOut  (triggerOut),
    .wTriggerIn  (wTriggerIn),
    .wAddrIn     (wAddrIn),
    .wDataIn     (wDataIn),
    .wTriggerOut (wTriggerOut)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input string name);
    logic prev;
    int   lat;
    prev = wTriggerOut;
    lat  = 0;
    wAddrIn    = a;
    wDataIn    = d;
    wTriggerIn = ~wTriggerIn;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (wTriggerOut != prev) begin
        lat = i;
        break;
      end
    end
    check32({name, "_wr_latency"}, lat, 32'd3);
    model_regs[a] = d;
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string name);
    logic prev;
    int   lat;
    prev = triggerOut;
    lat  = 0;
    addrIn    = a;
    triggerIn = ~triggerIn;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 3) check32({name, "_ready_low"}, {31'd0, readyOut}, 32'd0);
      if (triggerOut != prev) begin
        lat = i;
        break;
      end
    end
    check32({name, "_rd_latency"}, lat, 32'd4);
    check32({name, "_ready_high"}, {31'd0, readyOut}, 32'd1);
    check32({name, "_data"}, dataOut, exp);
  endtask

  // Read and write issued together; write toggles wdly cycles after the read.
  // The write commits 3 edges after its toggle, the read samples 4 edges after
  // its toggle, so the read sees the new value whenever commit edge <= read edge.
  task automatic rw_overlap(input logic [31:0] ra, input logic [3:0] wa, input logic [31:0] wd,
                            input int wdly, input string name);
    logic [31:0] exp_rd;
    logic [31:0] rdata;
    logic        rprev;
    logic        wprev;
    bit          got_r;
    bit          got_w;
    exp_rd = ((wa == ra[3:0]) && (wdly + 3 <= 4)) ? wd : model_regs[ra[3:0]];
    rprev  = triggerOut;
    wprev  = wTriggerOut;
    got_r  = 1'b0;
    got_w  = 1'b0;
    rdata  = 32'd0;
    addrIn    = ra;
    triggerIn = ~triggerIn;
    wAddrIn   = wa;
    wDataIn   = wd;
    if (wdly == 0) wTriggerIn = ~wTriggerIn;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (!got_r && (triggerOut != rprev)) begin
        got_r = 1'b1;
        rdata = dataOut;
      end
      if (!got_w && (wTriggerOut != wprev)) got_w = 1'b1;
      if (i == wdly) wTriggerIn = ~wTriggerIn;
      if (got_r && got_w) break;
    end
    check32({name, "_rd_ack"}, {31'd0, got_r}, 32'd1);
    check32({name, "_wr_ack"}, {31'd0, got_w}, 32'd1);
    check32({name, "_data"}, rdata, exp_rd);
    model_regs[wa] = wd;
  endtask

  initial begin
    vec_t        vecs [10];
    logic        prev;
    int          acks;
    logic [31:0] d1;
    logic [31:0] d2;

    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < 16; i++) model_regs[i] = 32'd0;
    reset      = 1'b1;
    triggerIn  = 1'b0;
    addrIn     = 32'd0;
    wTriggerIn = 1'b0;
    wAddrIn    = 4'd0;
    wDataIn    = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check32("reset_dataOut", dataOut, 32'd0);
    check32("reset_readyOut", {31'd0, readyOut}, 32'd0);
    check32("reset_triggerOut", {31'd0, triggerOut}, 32'd0);
    check32("reset_wTriggerOut", {31'd0, wTriggerOut}, 32'd0);

    do_read(32'd0, 32'h0000_0000, "rd_r0");
    check32("rd_r0_ack_phase", {31'd0, triggerOut}, 32'd1);

    do_write(4'd0, 32'h0000_00F0, "wr_r0");
    do_read(32'd0, 32'h0000_00F0, "rd_r0_after_wr");

    do_write(4'd5, 32'h1111_1111, "wr_r5");
    rw_overlap(32'd5, 4'd5, 32'h2222_2222, 1, "fwd_r5");
    do_read(32'd5, 32'h2222_2222, "rd_r5_after_fwd");

    do_write(4'd1, 32'h0000_000A, "wr_r1");
    do_write(4'd2, 32'h0000_000B, "wr_r2");
    prev = triggerOut;
    do_read(32'd1, 32'h0000_000A, "b2b_r1");
    check32("b2b_ack1", {31'd0, triggerOut}, {31'd0, ~prev});
    do_read(32'd2, 32'h0000_000B, "b2b_r2");
    check32("b2b_ack2", {31'd0, triggerOut}, {31'd0, prev});

    // Second toggle arrives while the first read is in READ
    do_write(4'd3, 32'h0000_0033, "wr_r3");
    prev      = triggerOut;
    acks      = 0;
    d1        = 32'd0;
    d2        = 32'd0;
    addrIn    = 32'd1;
    triggerIn = ~triggerIn;
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (triggerOut != prev) begin
        acks++;
        prev = triggerOut;
        if (acks == 1) d1 = dataOut;
        else d2 = dataOut;
      end
      if (i == 3) begin
        addrIn    = 32'd3;
        triggerIn = ~triggerIn;
      end
    end
    check32("busy_ack_count", acks, 32'd2);
    check32("busy_first_data", d1, 32'h0000_000A);
    check32("busy_second_data", d2, 32'h0000_0033);

    vecs[0] = '{1'b1, 32'd6,          32'hDEAD_BEEF, 32'd0};
    vecs[1] = '{1'b1, 32'd15,         32'hF00D_CAFE, 32'd0};
    vecs[2] = '{1'b0, 32'd6,          32'd0,         32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 32'hFFFF_FFF6,  32'd0,         32'hDEAD_BEEF};
    vecs[4] = '{1'b0, 32'h1234_567F,  32'd0,         32'hF00D_CAFE};
    vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFF, 32'd0};
    vecs[6] = '{1'b0, 32'h8000_0007,  32'd0,         32'hFFFF_FFFF};
    vecs[7] = '{1'b1, 32'd6,          32'h0000_0001, 32'd0};
    vecs[8] = '{1'b0, 32'd6,          32'd0,         32'h0000_0001};
    vecs[9] = '{1'b0, 32'h0000_0010,  32'd0,         32'h0000_00F0};
    for (int v = 0; v < 10; v++) begin
      if (vecs[v].is_wr) do_write(vecs[v].addr[3:0], vecs[v].data, $sformatf("vec%0d", v));
      else do_read(vecs[v].addr, vecs[v].exp, $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 30; r++) begin
      int          op;
      logic [31:0] ra;
      logic [3:0]  wa;
      logic [31:0] wd;
      op = $urandom_range(0, 2);
      ra = $urandom;
      wa = 4'($urandom_range(0, 15));
      wd = $urandom;
      if (op == 0) begin
        do_write(wa, wd, $sformatf("rnd%0d", r));
      end else if (op == 1) begin
        do_read(ra, model_regs[ra[3:0]], $sformatf("rnd%0d", r));
      end else begin
        if ($urandom_range(0, 1) == 1) wa = ra[3:0];
        rw_overlap(ra, wa, wd, $urandom_range(0, 2), $sformatf("rnd%0d_ovl", r));
      end
    end

    // Reset lands on the accept edge of an in-flight read
    addrIn    = 32'd0;
    triggerIn = ~triggerIn;
    repeat (2) @(negedge clk);
    reset      = 1'b1;
    triggerIn  = 1'b0;
    wTriggerIn = 1'b0;
    @(negedge clk);
    check32("midrst_readyOut", {31'd0, readyOut}, 32'd0);
    check32("midrst_triggerOut", {31'd0, triggerOut}, 32'd0);
    check32("midrst_wTriggerOut", {31'd0, wTriggerOut}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) model_regs[i] = 32'd0;
    repeat (6) @(negedge clk);
    check32("midrst_no_ack", {31'd0, triggerOut}, 32'd0);
    do_read(32'd0, model_regs[0], "midrst_r0");
    do_read(32'd6, model_regs[6], "midrst_r6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
